// File: rtl/cross_bar_slave_arbiter.sv
// Round-robin owner arbiter for one cross_bar slave port; holds the grant for the address phase and, for reads, the response.
// Optional watchdog release enabled by CROSS_BAR_ARB_TIMEOUT_EN.
module cross_bar_slave_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ID_W           = $clog2(N_MASTERS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [N_MASTERS-1:0] req_wr_i,
  input  logic                 slave_ack_i,
  input  logic                 slave_resp_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  if (N_MASTERS < 2 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("cross_bar_slave_arbiter: N_MASTERS and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        rr_ptr, rr_nxt;
  logic [ID_W-1:0]        win, id_nxt;
  logic                   win_vld;
  logic                   wr, wr_nxt;
  logic                   complete, to_resp, force_rel, release_evt;
  logic [N_MASTERS-1:0]   gnt_nxt;
  logic                   busy_nxt, tout_nxt;

  // First requester at or after rr_ptr, wrapping modulo N_MASTERS.
  always_comb begin
    int              m;
    logic [ID_W-1:0] idx;
    win     = '0;
    win_vld = 1'b0;
    m       = 0;
    idx     = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      m = int'(rr_ptr) + k;
      if (m >= N_MASTERS) m = m - N_MASTERS;
      idx = ID_W'(m);
      if (!win_vld && req_i[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    complete = 1'b0;
    to_resp  = 1'b0;
    case (state)
      ADDR: begin
        if (slave_ack_i) begin
          if (wr || slave_resp_i) complete = 1'b1;
          else                    to_resp  = 1'b1;
        end else if (!req_i[gnt_id_o]) begin
          complete = 1'b1;
        end
      end
      RESP:    complete = slave_resp_i;
      default: complete = 1'b0;
    endcase
  end

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog;

  assign force_rel = (state != IDLE) && !complete && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)             wdog <= '0;
    else if (state == IDLE) wdog <= '0;
    else                    wdog <= wdog + WD_W'(1);
  end
`else
  assign force_rel = 1'b0;
`endif

  assign release_evt = complete || force_rel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_o     <= '0;
      gnt_id_o  <= '0;
      busy_o    <= 1'b0;
      rr_ptr    <= '0;
      wr        <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_o     <= gnt_nxt;
      gnt_id_o  <= id_nxt;
      busy_o    <= busy_nxt;
      rr_ptr    <= rr_nxt;
      wr        <= wr_nxt;
      timeout_o <= tout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ADDR;
      ADDR: begin
        if (release_evt)  state_nxt = IDLE;
        else if (to_resp) state_nxt = RESP;
      end
      RESP:    if (release_evt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Release always lands in IDLE, which guarantees one bubble before the next grant.
  always_comb begin
    gnt_nxt  = gnt_o;
    id_nxt   = gnt_id_o;
    busy_nxt = busy_o;
    rr_nxt   = rr_ptr;
    wr_nxt   = wr;
    tout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_nxt  = N_MASTERS'(1) << win;
          id_nxt   = win;
          busy_nxt = 1'b1;
          wr_nxt   = req_wr_i[win];
        end
      end
      ADDR, RESP: begin
        if (release_evt) begin
          gnt_nxt  = '0;
          busy_nxt = 1'b0;
          rr_nxt   = (gnt_id_o == ID_W'(N_MASTERS - 1)) ? '0 : gnt_id_o + ID_W'(1);
          tout_nxt = force_rel;
        end
      end
      default: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// Bench for cross_bar_slave_arbiter: vector table, directed corner sequences, and random traffic against a transaction-level model.
module tb_cross_bar_slave_arbiter;

  localparam int N = 4;
  localparam int T = 8;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0, req_wr = '0;
  logic       ack = 1'b0, resp = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, timeout;

  always #5 clk = ~clk;

  cross_bar_slave_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_wr_i(req_wr),
    .slave_ack_i(ack), .slave_resp_i(resp),
    .gnt_o(gnt), .gnt_id_o(gnt_id), .busy_o(busy), .timeout_o(timeout)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model: who owns the slave, whether it waits for read data, and how long it has held it.
  int owner   = -1;
  int rr      = 0;
  int last_id = 0;
  int held    = 0;
  bit own_wr, want_data, tout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit done;
    tout = 1'b0;
    if (!rst_n) begin
      owner = -1; rr = 0; last_id = 0; held = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && req[(rr + k) % N]) begin
          owner     = (rr + k) % N;
          last_id   = owner;
          own_wr    = req_wr[owner];
          want_data = 1'b0;
          held      = 0;
        end
      end
    end else begin
      done = 1'b0;
      if (want_data) done = resp;
      else if (ack) begin
        if (own_wr || resp) done = 1'b1;
        else want_data = 1'b1;
      end else if (!req[owner]) done = 1'b1;
      if (!done && TO_EN && held == T - 1) begin
        done = 1'b1;
        tout = 1'b1;
      end
      held++;
      if (done) begin
        rr    = (owner + 1) % N;
        owner = -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt",     gnt,     (owner < 0) ? 0 : (1 << owner));
    chk("busy",    busy,    owner >= 0);
    chk("gnt_id",  gnt_id,  last_id);
    chk("timeout", timeout, tout);
    chk("onehot0", $onehot0(gnt), 1);
    chk("busy_vs_gnt", busy, |gnt);
  endtask

  typedef struct {
    bit         rst_n;
    logic [3:0] req;
    logic [3:0] wr;
    bit         ack;
    bit         resp;
    logic [3:0] exp_gnt;
    bit         exp_busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Reset with all requesting, then writes acked one cycle after each grant.
    tbl[0]  = '{1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1};
    tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0010, 1'b1};
    tbl[6]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b1};
    tbl[8]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 4'b1000, 1'b1};
    tbl[10] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1};
    tbl[12] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n; req = tbl[i].req; req_wr = tbl[i].wr;
      ack = tbl[i].ack; resp = tbl[i].resp;
      step();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
    end

    // Master 2 read: ack at t, resp at t+3; masters 0/3 wait out the response phase.
    req = 4'b0100; req_wr = 4'b0000; ack = 1'b0; resp = 1'b0;
    step(); chk("rd_grant", gnt, 4'b0100);
    ack = 1'b1;
    step(); chk("rd_t1", gnt, 4'b0100);
    ack = 1'b0; req = 4'b1001;
    step(); chk("rd_t2", gnt, 4'b0100);
    step(); chk("rd_t3", gnt, 4'b0100);
    resp = 1'b1;
    step(); chk("rd_t4", gnt, 4'b0000);
    resp = 1'b0;
    step(); chk("rd_t5", gnt, 4'b1000);

    // Master 3 read with ack and resp together; pointer wraps to 0.
    ack = 1'b1; resp = 1'b1;
    step(); chk("same_cyc_rel", gnt, 4'b0000);
    ack = 1'b0; resp = 1'b0; req = 4'b1111;
    step(); chk("wrap_grant", gnt, 4'b0001);

    // Reset while master 3 is in its response phase.
    ack = 1'b1; resp = 1'b1; req = 4'b1000;
    step();
    ack = 1'b0; resp = 1'b0;
    step(); chk("m3_grant", gnt, 4'b1000);
    ack = 1'b1;
    step(); chk("m3_resp", gnt, 4'b1000);
    ack = 1'b0; rst_n = 1'b0; req = 4'b1111;
    step(); chk("rst_gnt", gnt, 4'b0000); chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step(); chk("post_rst_grant", gnt, 4'b0001);
    ack = 1'b1; resp = 1'b1;
    step();
    ack = 1'b0; resp = 1'b0; req = 4'b0000;
    step();

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    // Write from master 1 that is never acked.
    req = 4'b0010; req_wr = 4'b0010;
    step(); chk("to_grant", gnt, 4'b0010);
    for (int i = 1; i < T; i++) begin
      step(); chk("to_hold", gnt, 4'b0010); chk("to_quiet", timeout, 1'b0);
    end
    step(); chk("to_rel_gnt", gnt, 4'b0000); chk("to_pulse", timeout, 1'b1);
    req = 4'b0110;
    step(); chk("to_next_grant", gnt, 4'b0100); chk("to_pulse_end", timeout, 1'b0);
    ack = 1'b1;
    step();
    ack = 1'b0; req = 4'b0000;
    step();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      req    = 4'($urandom);
      req_wr = 4'($urandom);
      ack    = ($urandom_range(0, 9) < 3);
      resp   = ($urandom_range(0, 9) < 3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
